// File: rtl/slave_resp_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : slave_resp_pkg
// Brief  : Shared types, constants and grant check for slave_resp_router.
// Rev    : 1.0  initial release
// ----------------------------------------------------------------------------
package slave_resp_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        STREAM = 2'd2
    } state_t;

    localparam int unsigned GRANT_NONE      = 0;
    localparam int unsigned SLAVE_GRANT_VLD = 0;

    // slave_grant carries {index, valid}; the index sits above the valid bit
    function automatic logic grant_legal(input int unsigned master,
                                         input int unsigned slave_grant,
                                         input int unsigned n_masters,
                                         input int unsigned n_slaves);
        int unsigned idx;
        idx = slave_grant >> 1;
        return (master != GRANT_NONE) && (master <= n_masters) &&
               slave_grant[SLAVE_GRANT_VLD] && (idx >= 1) && (idx <= n_slaves);
    endfunction

endpackage
`default_nettype wire

// File: rtl/slave_resp_router_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : slave_resp_router_if
// Brief  : Arbiter grant, slave response and routed master response bundle.
// Rev    : 1.0  initial release
// ----------------------------------------------------------------------------
interface slave_resp_router_if #(
    parameter int N_MASTERS = 2,
    parameter int N_SLAVES  = 3
);
    localparam int MW = $clog2(N_MASTERS + 1);
    localparam int SW = $clog2(N_SLAVES + 1);

    logic                 route_load;
    logic [MW-1:0]        bus_grant;
    logic [SW:0]          slave_grant;
    logic [N_SLAVES-1:0]  slave_valid;
    logic [N_SLAVES-1:0]  slave_ready;
    logic [N_SLAVES-1:0]  tx_data;
    logic [N_MASTERS-1:0] slave_valid_m;
    logic [N_MASTERS-1:0] slave_ready_m;
    logic [N_MASTERS-1:0] tx_data_m;
    logic [N_MASTERS-1:0] rx_done_m;
    logic [N_MASTERS-1:0] timeout_m;
    logic                 route_err;
    logic                 busy;

    // Router side
    modport slave (
        input  route_load, bus_grant, slave_grant, slave_valid, slave_ready, tx_data,
        output slave_valid_m, slave_ready_m, tx_data_m, rx_done_m, timeout_m,
               route_err, busy
    );

    // Arbiter / environment side
    modport master (
        output route_load, bus_grant, slave_grant, slave_valid, slave_ready, tx_data,
        input  slave_valid_m, slave_ready_m, tx_data_m, rx_done_m, timeout_m,
               route_err, busy
    );

endinterface
`default_nettype wire

// File: rtl/resp_frame_timer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : resp_frame_timer
// Brief  : Frame bit counter and idle-gap timeout counter, both saturating.
// Rev    : 1.0  initial release
// ----------------------------------------------------------------------------
module resp_frame_timer #(
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_clear,
    input  wire logic i_count_en,
    input  wire logic i_bit_valid,
    output logic      frame_last,
    output logic      timeout_hit
);
    localparam int BW = $clog2(DATA_WIDTH + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [BW-1:0] c_bit_max = BW'(DATA_WIDTH);
    localparam logic [BW-1:0] c_bit_lst = BW'(DATA_WIDTH - 1);
    localparam logic [TW-1:0] c_tmo_max = TW'(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] c_tmo_lst = TW'(TIMEOUT_CYCLES - 1);

    logic [BW-1:0] r_bit_cnt;
    logic [TW-1:0] r_tmo_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bit_cnt <= '0;
            r_tmo_cnt <= '0;
        end else if (i_clear) begin
            r_bit_cnt <= '0;
            r_tmo_cnt <= '0;
        end else if (i_count_en) begin
            if (i_bit_valid) begin
                if (r_bit_cnt != c_bit_max) r_bit_cnt <= r_bit_cnt + 1'b1;
                r_tmo_cnt <= '0;
            end else if (r_tmo_cnt != c_tmo_max) begin
                r_tmo_cnt <= r_tmo_cnt + 1'b1;
            end
        end
    end

    // Flags fire on the cycle whose update makes the counter reach its limit
    assign frame_last  = i_count_en &&  i_bit_valid && (r_bit_cnt == c_bit_lst);
    assign timeout_hit = i_count_en && !i_bit_valid && (r_tmo_cnt == c_tmo_lst);

endmodule
`default_nettype wire

// File: rtl/slave_resp_router.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : slave_resp_router
// Brief  : Registered slave-to-master serial response router with framing,
//          grant-withdrawal abort and response timeout.
// Rev    : 1.0  initial release
// ----------------------------------------------------------------------------
module slave_resp_router
    import slave_resp_pkg::*;
#(
    parameter int N_MASTERS      = 2,
    parameter int N_SLAVES       = 3,
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 64
) (
    input wire logic         clk,
    input wire logic         rst,
    slave_resp_router_if.slave bus
);
    localparam int MW = $clog2(N_MASTERS + 1);
    localparam int SW = $clog2(N_SLAVES + 1);

    state_t               r_state, w_state_nxt;
    logic [MW-1:0]        r_master, w_master_nxt;
    logic [SW-1:0]        r_slave, w_slave_nxt;
    logic [N_MASTERS-1:0] r_valid_m, r_ready_m, r_data_m, r_done_m, r_tmo_m;
    logic [N_MASTERS-1:0] w_valid_nxt, w_ready_nxt, w_data_nxt, w_done_nxt, w_tmo_nxt;
    logic                 r_route_err, w_err_nxt;
    logic                 w_sel_valid, w_sel_ready, w_sel_data;
    logic                 w_grant_ok, w_clear, w_route, w_tmo_pulse;
    logic                 w_frame_last, w_timeout_hit;

    assign w_grant_ok = grant_legal(32'(bus.bus_grant), 32'(bus.slave_grant),
                                    N_MASTERS, N_SLAVES);

    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_ready = 1'b0;
        w_sel_data  = 1'b0;
        for (int i = 0; i < N_SLAVES; i++) begin
            if (r_slave == SW'(i + 1)) begin
                w_sel_valid = bus.slave_valid[i];
                w_sel_ready = bus.slave_ready[i];
                w_sel_data  = bus.tx_data[i];
            end
        end
    end

    resp_frame_timer #(
        .DATA_WIDTH     (DATA_WIDTH),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk         (clk),
        .rst         (rst),
        .i_clear     (w_clear),
        .i_count_en  (r_state != IDLE),
        .i_bit_valid (w_sel_valid),
        .frame_last  (w_frame_last),
        .timeout_hit (w_timeout_hit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_master    <= '0;
            r_slave     <= '0;
            r_valid_m   <= '0;
            r_ready_m   <= '0;
            r_data_m    <= '0;
            r_done_m    <= '0;
            r_tmo_m     <= '0;
            r_route_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_master    <= w_master_nxt;
            r_slave     <= w_slave_nxt;
            r_valid_m   <= w_valid_nxt;
            r_ready_m   <= w_ready_nxt;
            r_data_m    <= w_data_nxt;
            r_done_m    <= w_done_nxt;
            r_tmo_m     <= w_tmo_nxt;
            r_route_err <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_master_nxt = r_master;
        w_slave_nxt  = r_slave;
        w_valid_nxt  = '0;
        w_ready_nxt  = '0;
        w_data_nxt   = '0;
        w_done_nxt   = '0;
        w_tmo_nxt    = '0;
        w_err_nxt    = 1'b0;
        w_clear      = 1'b0;
        w_route      = 1'b0;
        w_tmo_pulse  = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.route_load) begin
                    if (w_grant_ok) begin
                        w_state_nxt  = WAIT;
                        w_master_nxt = bus.bus_grant;
                        w_slave_nxt  = bus.slave_grant[SW:1];
                        w_clear      = 1'b1;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end
            end
            WAIT, STREAM: begin
                // Withdrawal beats completion, completion beats timeout
                if (bus.bus_grant != r_master) begin
                    w_state_nxt = IDLE;
                end else if (w_frame_last) begin
                    w_route     = 1'b1;
                    w_state_nxt = IDLE;
                end else if (w_timeout_hit) begin
                    w_tmo_pulse = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
                    w_route = 1'b1;
                    if (w_sel_valid) w_state_nxt = STREAM;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        for (int k = 0; k < N_MASTERS; k++) begin
            if (r_master == MW'(k + 1)) begin
                w_valid_nxt[k] = w_route & w_sel_valid;
                w_ready_nxt[k] = w_route & w_sel_ready;
                w_data_nxt[k]  = w_route & w_sel_data;
                w_done_nxt[k]  = w_route & w_frame_last;
                w_tmo_nxt[k]   = w_tmo_pulse;
            end
        end
    end

    assign bus.slave_valid_m = r_valid_m;
    assign bus.slave_ready_m = r_ready_m;
    assign bus.tx_data_m     = r_data_m;
    assign bus.rx_done_m     = r_done_m;
    assign bus.timeout_m     = r_tmo_m;
    assign bus.route_err     = r_route_err;
    assign bus.busy          = (r_state != IDLE);

endmodule
`default_nettype wire
